// File: rtl/elev_pkg.sv
// Direction encoding shared by the hall call scheduler, the motion FSM and
// the segment display decoding.
package elev_pkg;
   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DN   = 2'b10
   } dir_t;
endpackage

// File: rtl/hall_call_scheduler_if.sv
// Button, car-status and lamp/command signals between the front end,
// the scheduler and the motion FSM.
interface hall_call_scheduler_if
   import elev_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int FL_W     = 4
);
   logic [N_FLOORS-1:0] cab_btn;
   logic [N_FLOORS-1:0] hall_up;
   logic [N_FLOORS-1:0] hall_dn;
   logic [FL_W-1:0]     cur_floor;
   logic                at_floor;
   logic                car_idle;
   logic [N_FLOORS-1:0] cab_pend;
   logic [N_FLOORS-1:0] up_pend;
   logic [N_FLOORS-1:0] dn_pend;
   logic                any_pend;
   dir_t                dir;
   logic [FL_W-1:0]     target;
   logic                target_vld;

   modport master (
      output cab_btn, hall_up, hall_dn, cur_floor, at_floor, car_idle,
      input  cab_pend, up_pend, dn_pend, any_pend, dir, target, target_vld
   );

   modport slave (
      input  cab_btn, hall_up, hall_dn, cur_floor, at_floor, car_idle,
      output cab_pend, up_pend, dn_pend, any_pend, dir, target, target_vld
   );
endinterface

// File: rtl/hall_call_scheduler_btn_edge.sv
// Two-flop synchroniser followed by a rising-edge detector, one lane per button.
module btn_edge #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] press
);
   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;
   logic [W-1:0] prev_q, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign press = sync_q & ~prev_q;
endmodule

// File: rtl/hall_call_scheduler.sv
// Pending-call registry with SCAN direction control; issues the next stop
// floor to the motion FSM and drives the call lamps.
module hall_call_scheduler
   import elev_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int FL_W     = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   hall_call_scheduler_if.slave bus
);
   localparam logic [FL_W-1:0] TOP_FLOOR = FL_W'(N_FLOORS);

   logic [N_FLOORS-1:0] cab_press, up_press, dn_press, up_set, dn_set;
   logic [N_FLOORS-1:0] here_k, at_k, all_pend;
   logic [N_FLOORS-1:0] cab_pend_q, cab_pend_d, up_pend_q, up_pend_d, dn_pend_q, dn_pend_d;
   logic                any_pend_q, any_pend_d, cur_ok;
   logic [FL_W-1:0]     near_up, near_dn, gap_up, gap_dn;
   logic [FL_W-1:0]     target_q, target_d;
   logic                vld_q, vld_d;
   dir_t                dir_q, dir_d;

   // Nearest pending floor strictly above/below cur; 0 when there is none.
   function automatic logic [FL_W-1:0] pick(input logic [N_FLOORS-1:0] m,
                                            input logic [FL_W-1:0] cur,
                                            input logic above, input logic lowest);
      logic [FL_W-1:0] r, f;
      r = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         f = FL_W'(i + 1);
         if (m[i] && (above ? (f > cur) : (f < cur)) && (!lowest || r == '0)) r = f;
      end
      return r;
   endfunction

   btn_edge #(.W(N_FLOORS)) u_cab (.clk(clk), .rst_n(rst_n), .din(bus.cab_btn), .press(cab_press));
   btn_edge #(.W(N_FLOORS)) u_up  (.clk(clk), .rst_n(rst_n), .din(bus.hall_up), .press(up_press));
   btn_edge #(.W(N_FLOORS)) u_dn  (.clk(clk), .rst_n(rst_n), .din(bus.hall_dn), .press(dn_press));

   always_comb begin : call_registry
      cur_ok = (bus.cur_floor != '0) && (bus.cur_floor <= TOP_FLOOR);
      here_k = '0;
      for (int i = 0; i < N_FLOORS; i++) here_k[i] = cur_ok && (bus.cur_floor == FL_W'(i + 1));
      at_k = bus.at_floor ? here_k : '0;
      up_set = up_press;
      up_set[N_FLOORS-1] = 1'b0;
      dn_set = dn_press;
      dn_set[0] = 1'b0;
      // Clear is applied after set so a service strobe wins over a same-cycle press.
      cab_pend_d = (cab_pend_q | cab_press) & ~at_k;
      up_pend_d  = (up_pend_q | up_set) & ~((dir_q != DIR_DN) ? at_k : '0);
      dn_pend_d  = (dn_pend_q | dn_set) & ~((dir_q != DIR_UP) ? at_k : '0);
      any_pend_d = |{cab_pend_d, up_pend_d, dn_pend_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cab_pend_q <= '0;
         up_pend_q  <= '0;
         dn_pend_q  <= '0;
         any_pend_q <= 1'b0;
      end else begin
         cab_pend_q <= cab_pend_d;
         up_pend_q  <= up_pend_d;
         dn_pend_q  <= dn_pend_d;
         any_pend_q <= any_pend_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : dir_state
      if (!rst_n) begin
         dir_q    <= DIR_IDLE;
         target_q <= '0;
         vld_q    <= 1'b0;
      end else begin
         dir_q    <= dir_d;
         target_q <= target_d;
         vld_q    <= vld_d;
      end
   end

   always_comb begin : dir_next
      all_pend = cab_pend_q | up_pend_q | dn_pend_q;
      near_up  = pick(all_pend, bus.cur_floor, 1'b1, 1'b1);
      near_dn  = pick(all_pend, bus.cur_floor, 1'b0, 1'b0);
      gap_up   = near_up - bus.cur_floor;
      gap_dn   = bus.cur_floor - near_dn;
      dir_d    = dir_q;
      if (cur_ok && bus.car_idle) begin
         case (dir_q)
            DIR_IDLE: begin
               if (near_up != '0 && near_dn != '0) dir_d = (gap_up <= gap_dn) ? DIR_UP : DIR_DN;
               else if (near_up != '0)             dir_d = DIR_UP;
               else if (near_dn != '0)             dir_d = DIR_DN;
            end
            DIR_UP:  dir_d = (near_up != '0) ? DIR_UP : ((near_dn != '0) ? DIR_DN : DIR_IDLE);
            DIR_DN:  dir_d = (near_dn != '0) ? DIR_DN : ((near_up != '0) ? DIR_UP : DIR_IDLE);
            default: dir_d = DIR_IDLE;
         endcase
      end
   end

   always_comb begin : target_sel
      target_d = '0;
      if (cur_ok) begin
         case (dir_d)
            DIR_UP: begin
               target_d = pick(cab_pend_q | up_pend_q, bus.cur_floor, 1'b1, 1'b1);
               if (target_d == '0) target_d = pick(dn_pend_q, bus.cur_floor, 1'b1, 1'b0);
            end
            DIR_DN: begin
               target_d = pick(cab_pend_q | dn_pend_q, bus.cur_floor, 1'b0, 1'b0);
               if (target_d == '0) target_d = pick(up_pend_q, bus.cur_floor, 1'b0, 1'b1);
            end
            default: target_d = (|(all_pend & here_k)) ? bus.cur_floor : '0;
         endcase
      end
      vld_d = (target_d != '0);
   end

   assign bus.cab_pend   = cab_pend_q;
   assign bus.up_pend    = up_pend_q;
   assign bus.dn_pend    = dn_pend_q;
   assign bus.any_pend   = any_pend_q;
   assign bus.dir        = dir_q;
   assign bus.target     = target_q;
   assign bus.target_vld = vld_q;
endmodule

// File: tb/tb_hall_call_scheduler.sv
// Bench for hall_call_scheduler: directed scenarios plus random traffic
// against a floor-by-floor behavioural model of the call and SCAN rules.
module tb_hall_call_scheduler;
   localparam int N  = 4;
   localparam int FL = 4;
   localparam int VW = 3 * N + 1 + 2 + FL + 1;

   logic clk, rst_n;
   int   total, bad;

   hall_call_scheduler_if #(.N_FLOORS(N), .FL_W(FL)) bus ();
   hall_call_scheduler #(.N_FLOORS(N), .FL_W(FL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: input history per edge, pending calls, direction (0/1/2), target.
   logic [N-1:0] ch[4], uh[4], dh[4];
   logic [N-1:0] m_cab, m_up, m_dn;
   int           m_dir, m_tgt;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin ch[k] = '0; uh[k] = '0; dh[k] = '0; end
      m_cab = '0; m_up = '0; m_dn = '0; m_dir = 0; m_tgt = 0;
   endtask

   task automatic model_edge();
      logic [N-1:0] pc, pu, pd, clr, all;
      int cur, na, nb, nd, t;
      bit ok, here;
      if (!rst_n) begin model_reset(); return; end
      for (int k = 3; k > 0; k--) begin ch[k] = ch[k-1]; uh[k] = uh[k-1]; dh[k] = dh[k-1]; end
      ch[0] = bus.cab_btn; uh[0] = bus.hall_up; dh[0] = bus.hall_dn;
      // A press lands two edges after the input is first seen high, if it was low before.
      pc = ch[2] & ~ch[3];
      pu = uh[2] & ~uh[3]; pu[N-1] = 1'b0;
      pd = dh[2] & ~dh[3]; pd[0] = 1'b0;
      cur = int'(bus.cur_floor);
      ok = (cur >= 1) && (cur <= N);
      clr = '0;
      if (ok && bus.at_floor) clr[cur-1] = 1'b1;
      all = m_cab | m_up | m_dn;
      na = 0;
      for (int f = cur + 1; f <= N; f++) if (na == 0 && all[f-1]) na = f;
      nb = 0;
      for (int f = 1; f < cur && f <= N; f++) if (all[f-1]) nb = f;
      here = 1'b0;
      if (ok) here = all[cur-1];
      nd = m_dir;
      if (ok && bus.car_idle) begin
         if (m_dir == 0) begin
            if (na != 0 && nb != 0) nd = ((na - cur) <= (cur - nb)) ? 1 : 2;
            else if (na != 0) nd = 1;
            else if (nb != 0) nd = 2;
         end else if (m_dir == 1) nd = (na != 0) ? 1 : ((nb != 0) ? 2 : 0);
         else nd = (nb != 0) ? 2 : ((na != 0) ? 1 : 0);
      end
      t = 0;
      if (ok) begin
         if (nd == 1) begin
            for (int f = cur + 1; f <= N; f++) if (t == 0 && (m_cab[f-1] || m_up[f-1])) t = f;
            for (int f = N; f > cur; f--) if (t == 0 && m_dn[f-1]) t = f;
         end else if (nd == 2) begin
            for (int f = cur - 1; f >= 1; f--) if (t == 0 && (m_cab[f-1] || m_dn[f-1])) t = f;
            for (int f = 1; f < cur; f++) if (t == 0 && m_up[f-1]) t = f;
         end else t = here ? cur : 0;
      end
      m_cab = (m_cab | pc) & ~clr;
      m_up  = (m_up | pu) & ~((m_dir != 2) ? clr : '0);
      m_dn  = (m_dn | pd) & ~((m_dir != 1) ? clr : '0);
      m_dir = nd;
      m_tgt = t;
   endtask

   function automatic logic [VW-1:0] model_vec();
      return {m_cab, m_up, m_dn, |{m_cab, m_up, m_dn}, 2'(m_dir), FL'(m_tgt), m_tgt != 0};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {bus.cab_pend, bus.up_pend, bus.dn_pend, bus.any_pend, bus.dir, bus.target, bus.target_vld};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic pulse(input logic [N-1:0] c, input logic [N-1:0] u, input logic [N-1:0] d);
      bus.cab_btn = c; bus.hall_up = u; bus.hall_dn = d;
      step();
      bus.cab_btn = '0; bus.hall_up = '0; bus.hall_dn = '0;
   endtask

   task automatic clear_inputs();
      bus.cab_btn = '0; bus.hall_up = '0; bus.hall_dn = '0;
      bus.cur_floor = FL'(1); bus.at_floor = 1'b0; bus.car_idle = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (dut_vec() !== '0) begin bad++; $display("FAIL reset_state: got %h want %h", dut_vec(), {VW{1'b0}}); end
   endtask

   task automatic test_first_call();
      do_reset();
      bus.cur_floor = FL'(1); bus.car_idle = 1'b1;
      pulse(4'b0100, '0, '0);
      step();
      total++;
      if (bus.cab_pend !== 4'b0000) begin bad++; $display("FAIL latch_early: got %b want 0000", bus.cab_pend); end
      step();
      total++;
      if (bus.cab_pend !== 4'b0100 || bus.dir !== 2'b00) begin
         bad++; $display("FAIL latch_3edges: pend=%b dir=%b want 0100/00", bus.cab_pend, bus.dir);
      end
      step();
      total++;
      if (bus.dir !== 2'b01 || bus.target !== 4'd3 || bus.target_vld !== 1'b1) begin
         bad++; $display("FAIL first_dispatch: dir=%b tgt=%0d vld=%b want 01/3/1", bus.dir, bus.target, bus.target_vld);
      end
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL first_call_model: got %h want %h", dut_vec(), model_vec()); end
   endtask

   task automatic test_retarget();
      do_reset();
      bus.cur_floor = FL'(2); bus.car_idle = 1'b1;
      pulse(4'b1000, '0, '0);
      repeat (3) step();
      bus.car_idle = 1'b0;
      pulse('0, 4'b0100, '0);
      repeat (3) step();
      total++;
      if (bus.dir !== 2'b01 || bus.target !== 4'd3 || bus.up_pend !== 4'b0100) begin
         bad++; $display("FAIL retarget_up: dir=%b tgt=%0d up=%b want 01/3/0100", bus.dir, bus.target, bus.up_pend);
      end
      do_reset();
      bus.cur_floor = FL'(2); bus.car_idle = 1'b1;
      pulse(4'b1000, '0, '0);
      repeat (3) step();
      bus.car_idle = 1'b0;
      pulse('0, '0, 4'b0100);
      repeat (4) step();
      total++;
      if (bus.target !== 4'd4 || bus.dn_pend !== 4'b0100) begin
         bad++; $display("FAIL no_retarget_dn: tgt=%0d dn=%b want 4/0100", bus.target, bus.dn_pend);
      end
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL retarget_model: got %h want %h", dut_vec(), model_vec()); end
   endtask

   task automatic test_serve_clear();
      do_reset();
      bus.cur_floor = FL'(1); bus.car_idle = 1'b1;
      pulse('0, 4'b0100, 4'b0100);
      repeat (3) step();
      bus.car_idle = 1'b0; bus.cur_floor = FL'(3);
      step();
      bus.at_floor = 1'b1;
      step();
      total++;
      if (bus.up_pend !== 4'b0000 || bus.dn_pend !== 4'b0100) begin
         bad++; $display("FAIL serve_up_only: up=%b dn=%b want 0000/0100", bus.up_pend, bus.dn_pend);
      end
      bus.at_floor = 1'b0; bus.car_idle = 1'b1;
      step();
      total++;
      if (bus.dir !== 2'b00 || bus.target !== 4'd3 || bus.target_vld !== 1'b1) begin
         bad++; $display("FAIL serve_redirect: dir=%b tgt=%0d vld=%b want 00/3/1", bus.dir, bus.target, bus.target_vld);
      end
      bus.at_floor = 1'b1;
      step();
      bus.at_floor = 1'b0;
      total++;
      if (bus.dn_pend !== 4'b0000 || bus.any_pend !== 1'b0) begin
         bad++; $display("FAIL serve_idle_dn: dn=%b any=%b want 0000/0", bus.dn_pend, bus.any_pend);
      end
   endtask

   task automatic test_clear_beats_set();
      do_reset();
      bus.cur_floor = FL'(2); bus.car_idle = 1'b1; bus.at_floor = 1'b1;
      bus.cab_btn = 4'b0010;
      repeat (3) step();
      total++;
      if (bus.cab_pend !== 4'b0000) begin bad++; $display("FAIL clear_beats_set: got %b want 0000", bus.cab_pend); end
      repeat (97) step();
      bus.at_floor = 1'b0;
      repeat (10) step();
      total++;
      if (bus.cab_pend !== 4'b0000 || dut_vec() !== model_vec()) begin
         bad++; $display("FAIL held_no_relatch: got %h want %h", dut_vec(), model_vec());
      end
      bus.cab_btn = '0;
   endtask

   task automatic test_tie();
      do_reset();
      bus.cur_floor = FL'(2); bus.car_idle = 1'b1;
      pulse(4'b0101, '0, '0);
      repeat (3) step();
      total++;
      if (bus.dir !== 2'b01 || bus.target !== 4'd3) begin
         bad++; $display("FAIL tie_up: dir=%b tgt=%0d want 01/3", bus.dir, bus.target);
      end
      do_reset();
      bus.cur_floor = FL'(2); bus.car_idle = 1'b1;
      pulse(4'b1001, '0, '0);
      repeat (3) step();
      total++;
      if (bus.dir !== 2'b10 || bus.target !== 4'd1) begin
         bad++; $display("FAIL nearest_down: dir=%b tgt=%0d want 10/1", bus.dir, bus.target);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.cur_floor = FL'(2); bus.car_idle = 1'b1;
      pulse(4'b1101, 4'b0001, 4'b1000);
      repeat (3) step();
      bus.car_idle = 1'b0; bus.cur_floor = FL'(3);
      repeat (2) step();
      total++;
      if (dut_vec() !== model_vec() || bus.any_pend !== 1'b1) begin
         bad++; $display("FAIL five_calls: got %h want %h", dut_vec(), model_vec());
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (dut_vec() !== '0) begin bad++; $display("FAIL async_reset: got %h want %h", dut_vec(), {VW{1'b0}}); end
      repeat (2) step();
      rst_n = 1'b1;
      repeat (5) step();
      total++;
      if (dut_vec() !== '0) begin bad++; $display("FAIL post_reset_quiet: got %h want %h", dut_vec(), {VW{1'b0}}); end
      pulse(4'b0010, '0, '0);
      repeat (2) step();
      total++;
      if (bus.cab_pend !== 4'b0010) begin bad++; $display("FAIL post_reset_press: got %b want 0010", bus.cab_pend); end
   endtask

   task automatic test_invalid_floor();
      do_reset();
      bus.cur_floor = FL'(1); bus.car_idle = 1'b1;
      pulse(4'b0100, '0, '0);
      repeat (3) step();
      bus.cur_floor = FL'(0); bus.at_floor = 1'b1;
      pulse(4'b1000, '0, '0);
      repeat (2) step();
      total++;
      if (bus.target_vld !== 1'b0 || bus.target !== 4'd0 || bus.dir !== 2'b01 || bus.cab_pend !== 4'b1100) begin
         bad++; $display("FAIL floor0: vld=%b tgt=%0d dir=%b cab=%b want 0/0/01/1100",
                         bus.target_vld, bus.target, bus.dir, bus.cab_pend);
      end
      bus.cur_floor = FL'(5);
      repeat (2) step();
      total++;
      if (bus.target_vld !== 1'b0 || bus.cab_pend !== 4'b1100 || dut_vec() !== model_vec()) begin
         bad++; $display("FAIL floor_high: got %h want %h", dut_vec(), model_vec());
      end
      bus.at_floor = 1'b0;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 7) == 0) bus.cab_btn[b] = ~bus.cab_btn[b];
            if ($urandom_range(0, 9) == 0) bus.hall_up[b] = ~bus.hall_up[b];
            if ($urandom_range(0, 9) == 0) bus.hall_dn[b] = ~bus.hall_dn[b];
         end
         if ($urandom_range(0, 5) == 0) bus.cur_floor = FL'($urandom_range(0, 5));
         bus.at_floor = ($urandom_range(0, 3) == 0);
         bus.car_idle = ($urandom_range(0, 1) == 1);
         step();
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++;
            if (errs < 10) $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec(), model_vec());
            errs++;
         end
      end
      clear_inputs();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      test_reset();
      test_first_call();
      test_retarget();
      test_serve_clear();
      test_clear_beats_set();
      test_tie();
      test_reset_mid();
      test_invalid_floor();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
